// File: rtl/fifo_stream_reader_if.sv
// Read-port and output-stream bundle for fifo_stream_reader.
// master = the reader; slave = FIFO plus downstream consumer.
interface fifo_stream_reader_if #(
   parameter int WIDTH = 8
);
   logic             fifo_read_en;
   logic [WIDTH-1:0] fifo_read_data;
   logic             fifo_empty;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;

   modport master (
      output fifo_read_en, out_valid, out_data,
      input  fifo_read_data, fifo_empty, out_ready
   );

   modport slave (
      input  fifo_read_en, out_valid, out_data,
      output fifo_read_data, fifo_empty, out_ready
   );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side adapter: pops a registered-read FIFO and presents the words as a
// valid/ready stream through a 2-entry buffer, sustaining one word per cycle.
module fifo_stream_reader #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   fifo_stream_reader_if.master bus,
   output logic                 busy,
   output logic [CNT_W-1:0]     xfer_count
);
   logic [1:0]       occ_q, occ_d;
   logic             inflight_q, inflight_d;
   logic [WIDTH-1:0] buf0_q, buf0_d;
   logic [WIDTH-1:0] buf1_q, buf1_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;

   logic             pop_s;
   logic             read_en_s;
   logic [1:0]       level_s;
   logic [1:0]       occ_pop_s;

   // Issue rule, pop/shift/capture and next-state computation
   always_comb begin
      pop_s      = (occ_q != 2'd0) && bus.out_ready;
      level_s    = occ_q + {1'b0, inflight_q} - {1'b0, pop_s};
      read_en_s  = !reset && enable && !bus.fifo_empty && (level_s < 2'd2);
      occ_pop_s  = occ_q - {1'b0, pop_s};
      buf1_d     = buf1_q;
      if (pop_s && (occ_q == 2'd2)) begin
         buf0_d = buf1_q;
      end else begin
         buf0_d = buf0_q;
      end
      // The captured word lands in the first slot left free after the pop.
      if (inflight_q) begin
         case (occ_pop_s)
            2'd0:    buf0_d = bus.fifo_read_data;
            2'd1:    buf1_d = bus.fifo_read_data;
            default: buf1_d = buf1_q;
         endcase
      end else begin
         buf1_d = buf1_d;
      end
      occ_d      = occ_pop_s + {1'b0, inflight_q};
      inflight_d = read_en_s;
      cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, pop_s};
      busy_d     = (occ_d != 2'd0) || inflight_d;
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         buf0_q     <= {WIDTH{1'b0}};
         buf1_q     <= {WIDTH{1'b0}};
         cnt_q      <= {CNT_W{1'b0}};
         busy_q     <= 1'b0;
      end else begin
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         buf0_q     <= buf0_d;
         buf1_q     <= buf1_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.fifo_read_en = read_en_s;
   assign bus.out_valid    = (occ_q != 2'd0);
   assign bus.out_data     = buf0_q;
   assign busy             = busy_q;
   assign xfer_count       = cnt_q;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench: FIFO model feeds the reader, a scoreboard queue holds
// every word loaded and is compared against each accepted output word.
module tb_fifo_stream_reader;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        busy, busy4;
   logic [15:0] xfer_count;
   logic [3:0]  xfer_count4;

   fifo_stream_reader_if #(.WIDTH(8)) bus ();
   fifo_stream_reader_if #(.WIDTH(8)) bus4 ();

   fifo_stream_reader #(.WIDTH(8), .CNT_W(16)) u_dut (
      .clk(clk), .reset(reset), .enable(enable), .bus(bus),
      .busy(busy), .xfer_count(xfer_count)
   );

   // Twin with a 4-bit counter, fed identical inputs, for the wrap check
   fifo_stream_reader #(.WIDTH(8), .CNT_W(4)) u_dut4 (
      .clk(clk), .reset(reset), .enable(enable), .bus(bus4),
      .busy(busy4), .xfer_count(xfer_count4)
   );
   assign bus4.fifo_read_data = bus.fifo_read_data;
   assign bus4.fifo_empty     = bus.fifo_empty;
   assign bus4.out_ready      = bus.out_ready;

   always #5 clk = ~clk;

   logic [7:0] fq[$];
   logic [7:0] sb[$];
   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int rd_total = 0;
   int outstanding = 0;
   int first_rd = -1;
   int first_valid = -1;
   int run_len = 0;
   int max_run = 0;
   int loaded = 0;
   int rd_base;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [7:0] v);
      fq.push_back(v);
      sb.push_back(v);
      bus.fifo_empty = 1'b0;
   endtask

   // One clock cycle: sample before the edge, then advance the FIFO model
   task automatic tick();
      logic rd, pp, rst_s;
      logic [7:0] exp;
      #1;
      rd    = bus.fifo_read_en;
      pp    = bus.out_valid && bus.out_ready;
      rst_s = reset;
      check_eq("rd_while_empty", {31'd0, rd && bus.fifo_empty}, 32'd0);
      if (pp === 1'b1) begin
         if (sb.size() == 0) begin
            check_eq("extra_word", 32'(sb.size()), 32'd1);
         end else begin
            exp = sb.pop_front();
            check_eq("out_data", {24'd0, bus.out_data}, {24'd0, exp});
         end
      end
      if (bus.out_valid === 1'b1) begin
         run_len++;
         if (first_valid < 0) first_valid = cyc;
      end else begin
         run_len = 0;
      end
      if (run_len > max_run) max_run = run_len;
      if (rd === 1'b1) begin
         rd_total++;
         if (first_rd < 0) first_rd = cyc;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (rst_s) outstanding = 0;
      else outstanding = outstanding + int'(rd === 1'b1) - int'(pp === 1'b1);
      check_eq("occ_bound", {31'd0, outstanding <= 2}, 32'd1);
      if ((rd === 1'b1) && (fq.size() > 0)) bus.fifo_read_data = fq.pop_front();
      bus.fifo_empty = (fq.size() == 0);
   endtask

   initial begin
      bus.out_ready      = 1'b0;
      bus.fifo_empty     = 1'b1;
      bus.fifo_read_data = 8'h00;

      // Reset with a non-empty FIFO: nothing may be issued
      load(8'hA5);
      for (int i = 0; i < 2; i++) begin
         tick();
         check_eq("rst_read_en", {31'd0, bus.fifo_read_en}, 32'd0);
         check_eq("rst_valid", {31'd0, bus.out_valid}, 32'd0);
         check_eq("rst_data", {24'd0, bus.out_data}, 32'd0);
         check_eq("rst_xfer", {16'd0, xfer_count}, 32'd0);
         check_eq("rst_busy", {31'd0, busy}, 32'd0);
      end

      // Single word
      reset = 1'b0; enable = 1'b1; bus.out_ready = 1'b1;
      first_rd = -1; first_valid = -1; rd_base = rd_total;
      for (int i = 0; i < 8; i++) tick();
      check_eq("single_reads", 32'(rd_total - rd_base), 32'd1);
      check_eq("single_latency", 32'(first_valid - first_rd), 32'd2);
      check_eq("single_xfer", {16'd0, xfer_count}, 32'd1);
      check_eq("single_drained", 32'(sb.size()), 32'd0);

      // Streaming 8 words back-to-back
      for (int i = 1; i <= 8; i++) load(8'(i));
      max_run = 0;
      for (int i = 0; i < 20; i++) tick();
      check_eq("stream_run", 32'(max_run), 32'd8);
      check_eq("stream_xfer", {16'd0, xfer_count}, 32'd9);
      check_eq("stream_drained", 32'(sb.size()), 32'd0);

      // Backpressure
      bus.out_ready = 1'b0;
      for (int i = 0; i < 6; i++) load(8'h10 + 8'(i));
      rd_base = rd_total;
      for (int i = 0; i < 10; i++) tick();
      check_eq("stall_reads", 32'(rd_total - rd_base), 32'd2);
      check_eq("stall_valid", {31'd0, bus.out_valid}, 32'd1);
      check_eq("stall_data", {24'd0, bus.out_data}, 32'h10);
      check_eq("stall_busy", {31'd0, busy}, 32'd1);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      check_eq("stall_drained", 32'(sb.size()), 32'd0);
      check_eq("stall_xfer", {16'd0, xfer_count}, 32'd15);

      // Random stalls with enable toggling
      loaded = 0;
      for (int i = 0; i < 6000 && (loaded < 200 || sb.size() != 0); i++) begin
         if (loaded < 200 && $urandom_range(0, 2) != 0) begin
            load(8'($urandom_range(0, 255)));
            loaded++;
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         enable        = ($urandom_range(0, 3) != 0);
         tick();
      end
      enable = 1'b1; bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      check_eq("random_loaded", 32'(loaded), 32'd200);
      check_eq("random_drained", 32'(sb.size()), 32'd0);
      check_eq("random_xfer", {16'd0, xfer_count}, 32'd215);

      // Reset with a buffered word and a read in flight
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) load(8'hC0 + 8'(i));
      tick();
      tick();
      check_eq("pre_rst_outstanding", 32'(outstanding), 32'd2);
      reset = 1'b1;
      tick();
      check_eq("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
      check_eq("midrst_busy", {31'd0, busy}, 32'd0);
      check_eq("midrst_xfer", {16'd0, xfer_count}, 32'd0);
      check_eq("midrst_read_en", {31'd0, bus.fifo_read_en}, 32'd0);
      sb = fq;
      reset = 1'b0; bus.out_ready = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      check_eq("midrst_drained", 32'(sb.size()), 32'd0);
      check_eq("midrst_xfer_after", {16'd0, xfer_count}, 32'd2);

      // Counter wrap on the 4-bit twin
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 17; i++) load(8'h80 + 8'(i));
      for (int i = 0; i < 30; i++) tick();
      check_eq("wrap_drained", 32'(sb.size()), 32'd0);
      check_eq("wrap_xfer4", {28'd0, xfer_count4}, 32'd1);
      check_eq("wrap_xfer16", {16'd0, xfer_count}, 32'd17);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
